// File: rtl/countdown_tick_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | countdown_tick_ctrl: load/tick/expiry control for a 2-digit BCD timer.     |
// | Optional pause support is enabled by defining COUNTDOWN_PAUSE_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module countdown_tick_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic [3:0] cfg_tens,
  input  logic [3:0] cfg_units,
  input  logic [3:0] digit_tens,
  input  logic [3:0] digit_units,
  output logic       reconfig,
  output logic [3:0] setDigit_tens,
  output logic [3:0] setDigit_units,
  output logic       decrement,
  output logic       reset_timer,
  output logic       running,
  output logic       timeout
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
`ifdef COUNTDOWN_PAUSE_EN
  localparam logic [2:0] PAUSED = 3'd4;
`else
  logic unused_pause;
  assign unused_pause = pause;
`endif

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [3:0]    tens_q;
  logic [3:0]    units_q;
  logic          digits_zero;
  logic          at_term;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign digits_zero = (digit_tens == 4'd0) && (digit_units == 4'd0);
  assign at_term     = (presc == TERM);

  // Strobes decode only registered state, prescaler and timer feedback.
  assign reconfig       = (state == LOAD);
  assign running        = (state == RUN);
  assign decrement      = (state == RUN) && !digits_zero && at_term;
  assign setDigit_tens  = tens_q;
  assign setDigit_units = units_q;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    if (abort) begin
      state_nxt = IDLE;
      presc_nxt = '0;
    end else if (start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        LOAD: begin
          state_nxt = RUN;
          presc_nxt = '0;
        end
        RUN: begin
          // Zero check outranks both the terminal count and a pause request.
          if (digits_zero) begin
            state_nxt = DONE;
          end else begin
            presc_nxt = at_term ? '0 : presc + 1'b1;
`ifdef COUNTDOWN_PAUSE_EN
            if (pause) state_nxt = PAUSED;
`endif
          end
        end
`ifdef COUNTDOWN_PAUSE_EN
        PAUSED: begin
          if (!pause) state_nxt = RUN;
        end
`endif
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      presc       <= '0;
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
      reset_timer <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc       <= presc_nxt;
      reset_timer <= abort;
      timeout     <= (state_nxt == DONE) && (state != DONE);
      if (start && !abort) begin
        tens_q  <= clamp_bcd(cfg_tens);
        units_q <= clamp_bcd(cfg_units);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_tick_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_countdown_tick_ctrl: directed bench with a BCD countdown timer model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_countdown_tick_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       pause;
  logic [3:0] cfg_tens;
  logic [3:0] cfg_units;
  logic [3:0] digit_tens;
  logic [3:0] digit_units;
  logic       reconfig;
  logic [3:0] setDigit_tens;
  logic [3:0] setDigit_units;
  logic       decrement;
  logic       reset_timer;
  logic       running;
  logic       timeout;

  int checks;
  int errors;
  int cyc, dec_cnt, first_dec, to_cnt, first_to, rcfg_cnt, rt_cnt, run_cnt;

  countdown_tick_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .pause          (pause),
    .cfg_tens       (cfg_tens),
    .cfg_units      (cfg_units),
    .digit_tens     (digit_tens),
    .digit_units    (digit_units),
    .reconfig       (reconfig),
    .setDigit_tens  (setDigit_tens),
    .setDigit_units (setDigit_units),
    .decrement      (decrement),
    .reset_timer    (reset_timer),
    .running        (running),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural two-digit BCD down counter standing in for the timer.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_tens  <= 4'd0;
      digit_units <= 4'd0;
    end else if (reset_timer) begin
      digit_tens  <= 4'd0;
      digit_units <= 4'd0;
    end else if (reconfig) begin
      digit_tens  <= setDigit_tens;
      digit_units <= setDigit_units;
    end else if (decrement) begin
      if (digit_units != 4'd0) begin
        digit_units <= digit_units - 4'd1;
      end else if (digit_tens != 4'd0) begin
        digit_tens  <= digit_tens - 4'd1;
        digit_units <= 4'd9;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; dec_cnt = 0; first_dec = 0; to_cnt = 0; first_to = 0;
    rcfg_cnt = 0; rt_cnt = 0; run_cnt = 0;
  endtask

  task automatic observe(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cyc++;
      if (decrement) begin
        dec_cnt++;
        if (first_dec == 0) first_dec = cyc;
      end
      if (timeout) begin
        to_cnt++;
        if (first_to == 0) first_to = cyc;
      end
      if (reconfig)    rcfg_cnt++;
      if (reset_timer) rt_cnt++;
      if (running)     run_cnt++;
    end
  endtask

  task automatic pulse_start(input logic [3:0] t, input logic [3:0] u);
    start = 1'b1; cfg_tens = t; cfg_units = u;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, reconfig, setDigit_tens, setDigit_units,
            decrement, reset_timer, running, timeout};
  endfunction

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
    cfg_tens = 4'd0; cfg_units = 4'd0;
    clear_obs();
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic countdown from 03
    pulse_start(4'd0, 4'd3);
    check("basic_reconfig", {31'd0, reconfig}, 32'd1);
    check("basic_setdigit", {24'd0, setDigit_tens, setDigit_units}, 32'h03);
    check("basic_load_notrun", {31'd0, running}, 32'd0);
    clear_obs();
    observe(20);
    check("basic_dec_cnt", dec_cnt, 3);
    check("basic_first_dec", first_dec, 4);
    check("basic_to_cycle", first_to, 14);
    check("basic_to_cnt", to_cnt, 1);
    check("basic_run_cnt", run_cnt, 13);
    check("basic_rcfg_cnt", rcfg_cnt, 0);
    check("basic_digits", {24'd0, digit_tens, digit_units}, 32'h00);
    check("basic_running_end", {31'd0, running}, 32'd0);

    // Clamp, then abort after the 2nd decrement
    pulse_start(4'hF, 4'hC);
    check("clamp_reconfig", {31'd0, reconfig}, 32'd1);
    check("clamp_setdigit", {24'd0, setDigit_tens, setDigit_units}, 32'h99);
    clear_obs();
    observe(8);
    check("clamp_dec_cnt", dec_cnt, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_reset_timer", {31'd0, reset_timer}, 32'd1);
    check("abort_running", {31'd0, running}, 32'd0);
    check("abort_dec", {31'd0, decrement}, 32'd0);
    clear_obs();
    observe(20);
    check("abort_no_dec", dec_cnt, 0);
    check("abort_rt_once", rt_cnt, 0);
    check("abort_idle", run_cnt, 0);
    check("abort_digits", {24'd0, digit_tens, digit_units}, 32'h00);

    // Abort and start together: abort wins
    start = 1'b1; abort = 1'b1; cfg_tens = 4'd2; cfg_units = 4'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abst_reconfig", {31'd0, reconfig}, 32'd0);
    check("abst_reset_timer", {31'd0, reset_timer}, 32'd1);
    clear_obs();
    observe(10);
    check("abst_rcfg_cnt", rcfg_cnt, 0);
    check("abst_run_cnt", run_cnt, 0);
    check("abst_latch_kept", {24'd0, setDigit_tens, setDigit_units}, 32'h99);

    // Restart mid-RUN with 15
    pulse_start(4'd0, 4'd9);
    clear_obs();
    observe(6);
    check("pre_restart_dec", dec_cnt, 1);
    pulse_start(4'd1, 4'd5);
    check("restart_reconfig", {31'd0, reconfig}, 32'd1);
    check("restart_setdigit", {24'd0, setDigit_tens, setDigit_units}, 32'h15);
    clear_obs();
    observe(10);
    check("restart_first_dec", first_dec, 4);
    check("restart_dec_cnt", dec_cnt, 2);
    check("restart_digits", {24'd0, digit_tens, digit_units}, 32'h13);

    // Pause for 10 cycles starting where the prescaler reaches 2
    pause = 1'b1;
    clear_obs();
    observe(10);
`ifdef COUNTDOWN_PAUSE_EN
    check("pause_dec_cnt", dec_cnt, 0);
    check("pause_run_cnt", run_cnt, 0);
`else
    check("nopause_dec_cnt", dec_cnt, 3);
    check("nopause_run_cnt", run_cnt, 10);
`endif
    pause = 1'b0;
    clear_obs();
    observe(6);
`ifdef COUNTDOWN_PAUSE_EN
    check("resume_first_dec", first_dec, 2);
    check("resume_dec_cnt", dec_cnt, 2);
    check("resume_digits", {24'd0, digit_tens, digit_units}, 32'h11);
`else
    check("nopause_first_dec", first_dec, 4);
    check("nopause_dec_cnt2", dec_cnt, 1);
    check("nopause_digits", {24'd0, digit_tens, digit_units}, 32'h09);
`endif

    // Asynchronous reset mid-RUN
    check("prereset_running", {31'd0, running}, 32'd1);
    #2 reset = 1'b0;
    #1 check("async_reset_outs", outs(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_obs();
    observe(20);
    check("post_reset_strobes", dec_cnt + to_cnt + rcfg_cnt + rt_cnt + run_cnt, 0);
    check("post_reset_outs", outs(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/countdown_tick_ctrl.md
# countdown_tick_ctrl

Control stage directly upstream of the two-digit BCD countdown timer. It latches a requested start value and drives it onto the timer's load inputs. It converts the system clock into a one-cycle `decrement` strobe every `TICK_DIV` cycles, watches the timer's digit outputs for 00, and reports expiry. It also provides abort and, optionally, pause control for the game round.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per countdown step; legal range ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to (re)load and start the countdown.
- `abort`  in  1  one-cycle request to stop and clear the countdown.
- `pause`  in  1  level; holds the countdown while high (see Configuration).
- `cfg_tens`  in  4  requested tens digit, BCD.
- `cfg_units`  in  4  requested units digit, BCD.
- `digit_tens`  in  4  current tens digit fed back from the timer.
- `digit_units`  in  4  current units digit fed back from the timer.
- `reconfig`  out  1  timer load strobe.
- `setDigit_tens`  out  4  load value, tens digit.
- `setDigit_units`  out  4  load value, units digit.
- `decrement`  out  1  timer step strobe.
- `reset_timer`  out  1  timer clear strobe.
- `running`  out  1  high while in RUN.
- `timeout`  out  1  one-cycle expiry pulse.

## Operation
- States: IDLE, LOAD, RUN, PAUSED, DONE. Reset state is IDLE.
- Reset values: all outputs 0, prescaler 0, latched digits 0.
- Input priority when events coincide: abort > start > pause.
- **abort**, sampled in any state:
  - next state IDLE;
  - `reset_timer` high for exactly the next cycle;
  - prescaler cleared.
- **start**, sampled in any state other than on an abort cycle:
  - latch `cfg_tens` and `cfg_units`; any value > 9 is clamped to 9;
  - next state LOAD.
  - Start during RUN, PAUSED or DONE restarts the round with the new values.
- **LOAD** (exactly 1 cycle):
  - `reconfig` = 1;
  - `setDigit_*` = latched values;
  - prescaler cleared;
  - next state RUN.
- `setDigit_*` holds the latched values in every state, so the timer only samples them while `reconfig` is high.
- **RUN**:
  - `running` = 1.
  - If `digit_tens` = 0 and `digit_units` = 0: next state DONE, no decrement.
  - Otherwise the prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - `decrement` = 1 in the cycle where prescaler = TICK_DIV-1 and the digits are nonzero.
  - When the zero check and the terminal count coincide, the zero check wins and no decrement is issued.
- **DONE**:
  - `timeout` = 1 in the first DONE cycle only;
  - all other strobes 0;
  - state held until start or abort.
- Prescaler width is ceil(log2(TICK_DIV)) and it never exceeds TICK_DIV-1.
- `decrement` and `reconfig` are decoded from registered state, the prescaler, and the digit inputs only. There is no combinational path from `start`, `abort` or `pause`.

## Timing
- `start` sampled at edge k gives:
  - `reconfig` high during cycle k..k+1;
  - RUN from edge k+1;
  - the first `decrement` in the TICK_DIV-th RUN cycle.
- From loading value N (two-digit, nonzero) to `timeout`: N × TICK_DIV RUN cycles, plus 1 cycle for the zero check, plus entry into DONE.
- Loading 00 gives DONE two edges after start and `timeout` with no `decrement`.
- `abort` at edge k gives `reset_timer` high during cycle k..k+1 and `running` low from edge k.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge. Release is synchronous to the next `clk` edge.

## Configuration
- Macro: `COUNTDOWN_PAUSE_EN`.
- **Defined:**
  - `pause` high in RUN moves to PAUSED at the next edge;
  - PAUSED holds the prescaler value, with `decrement` = 0 and `running` = 0;
  - `pause` low returns to RUN, and the prescaler resumes from the held value;
  - a zero check is not performed in PAUSED.
- **Undefined:**
  - the `pause` port is present but ignored;
  - PAUSED is unreachable, and its state encoding may be removed.

## Test plan
Bench parameters: TICK_DIV = 4; a behavioural BCD countdown model drives the digit inputs.
- **Reset:** assert `reset` = 0 mid-RUN → all outputs 0 asynchronously; after release, state is IDLE and no strobes appear for 20 cycles.
- **Basic countdown:** `start` with `cfg` = 0/3 → `reconfig` for 1 cycle with `setDigit` = 0/3; `decrement` every 4th cycle, 3 pulses; digits reach 00; one `timeout` pulse; `running` falls.
- **Clamp:** `cfg_units` = 0xC, `cfg_tens` = 0xF → `setDigit_tens` = 9 and `setDigit_units` = 9 during LOAD.
- **Abort:** `abort` after the 2nd decrement → `reset_timer` for 1 cycle, IDLE, no further `decrement`. `abort` and `start` in the same cycle → abort wins and no `reconfig`.
- **Restart:** `start` with 1/5 in mid-RUN → LOAD; prescaler restarts, so the next `decrement` comes exactly 4 RUN cycles later.
- **Pause, macro on:** `pause` high for 10 cycles after prescaler = 2 → no `decrement` and `running` = 0; after release, `decrement` comes 2 cycles later.
- **Pause, macro off:** same stimulus → `pause` has no effect.
